// File: rtl/wb_program_loader.sv
// Wishbone master that copies a streamed program image into memory,
// then hands the memory over to the core via core_select.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start, len             begin a load of len words (IDLE/DONE/ERROR only)
//   pause                  hold the transfer; cyc stays high, stb drops
//   src_valid/data/ready   input word stream
//   cyc, stb, we           Wishbone master control
//   ADR_O, DAT_O, ack      Wishbone address, data and acknowledge
//   core_select            0 = loader owns memory, 1 = core owns memory
//   busy, done, err        status: active, completion pulse, sticky timeout
//   words_written          acked writes in the current load
module wb_program_loader #(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                ACK_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] len,
   input  logic              pause,
   input  logic              src_valid,
   input  logic [DATA_W-1:0] src_data,
   output logic              src_ready,
   output logic              cyc,
   output logic              stb,
   output logic              we,
   output logic [ADDR_W-1:0] ADR_O,
   output logic [DATA_W-1:0] DAT_O,
   input  logic              ack,
   output logic              core_select,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] words_written
);

   localparam int TMR_W = $clog2(ACK_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WRITE,
      S_PAUSE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic              cyc_q, cyc_d;
   logic              stb_q, stb_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic              core_q, core_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;

   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      stb_d     = stb_q;
      we_d      = we_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      core_d    = core_q;
      done_d    = 1'b0;
      err_d     = err_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      addr_d    = addr_q;
      tmr_d     = tmr_q;
      src_ready = 1'b0;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               len_d  = len;
               addr_d = BASE_ADDR;
               cnt_d  = '0;
               err_d  = 1'b0;
               core_d = 1'b0;
               if (len == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  core_d  = 1'b1;
               end else begin
                  state_d = S_FETCH;
                  cyc_d   = 1'b1;
               end
            end
         end
         S_FETCH: begin
            src_ready = !pause;
            if (src_valid && !pause) begin
               dat_d   = src_data;
               adr_d   = addr_q;
               stb_d   = 1'b1;
               we_d    = 1'b1;
               tmr_d   = '0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            // ack beats pause: a word acked here is always counted
            if (ack) begin
               stb_d  = 1'b0;
               addr_d = addr_q + ADDR_W'(1);
               cnt_d  = cnt_q + ADDR_W'(1);
               if (cnt_q + ADDR_W'(1) == len_q) begin
                  state_d = S_DONE;
                  cyc_d   = 1'b0;
                  we_d    = 1'b0;
                  core_d  = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_FETCH;
               end
            end else if (pause) begin
               stb_d   = 1'b0;
               state_d = S_PAUSE;
            end else if (tmr_q == TMR_LAST) begin
               state_d = S_ERROR;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               we_d    = 1'b0;
               err_d   = 1'b1;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         S_PAUSE: begin
            // same word is re-presented; ADR/DAT never changed
            if (!pause) begin
               stb_d   = 1'b1;
               tmr_d   = '0;
               state_d = S_WRITE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_FETCH) || (state_d == S_WRITE) ||
               (state_d == S_PAUSE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         core_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         len_q   <= '0;
         addr_q  <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         core_q  <= core_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         tmr_q   <= tmr_d;
      end
   end

   assign cyc           = cyc_q;
   assign stb           = stb_q;
   assign we            = we_q;
   assign ADR_O         = adr_q;
   assign DAT_O         = dat_q;
   assign core_select   = core_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign words_written = cnt_q;

endmodule

// File: tb/tb_wb_program_loader.sv
// Bench for wb_program_loader: stream source, acking slave and
// a scoreboard of expected (address, data) writes.
module tb_wb_program_loader;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam logic [AW-1:0] BASE = 32'h0;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] len = '0;
   logic          pause = 1'b0;
   logic          src_valid = 1'b0;
   logic [DW-1:0] src_data = '0;
   logic          src_ready;
   logic          cyc, stb, we;
   logic [AW-1:0] ADR_O;
   logic [DW-1:0] DAT_O;
   logic          ack = 1'b0;
   logic          core_select, busy, done, err;
   logic [AW-1:0] words_written;

   wb_program_loader #(
      .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE), .ACK_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .len(len),
      .pause(pause), .src_valid(src_valid), .src_data(src_data),
      .src_ready(src_ready), .cyc(cyc), .stb(stb), .we(we),
      .ADR_O(ADR_O), .DAT_O(DAT_O), .ack(ack),
      .core_select(core_select), .busy(busy), .done(done),
      .err(err), .words_written(words_written)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q [$];
   logic [DW-1:0] img [$];
   int src_idx = 0;
   int src_mode = 0;
   int phase = 0;
   bit hs_pend = 0;
   bit stb_prev = 0;
   int ack_cnt = 0;
   int acks_given = 0;
   int ack_stop_at = 1 << 30;
   int done_cnt = 0;
   int nwrites = 0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Source and slave act on the falling edge; the main sequence only
   // changes inputs 2ns after the rising edge, so what is seen here
   // holds up to the next rising edge.
   always @(negedge clk) begin
      if (reset) begin
         ack = 1'b0;
         ack_cnt = 0;
         hs_pend = 0;
         src_valid = 1'b0;
      end else begin
         if (src_mode == 1 && stb && !stb_prev)
            chk("stb_after_hs", 64'(hs_pend), 64'd1);
         if (hs_pend) src_idx++;
         hs_pend = 0;
         phase++;
         src_valid = (src_idx < img.size()) &&
                     (src_mode == 0 || phase % 4 == 0);
         src_data = (src_idx < img.size()) ? img[src_idx] : '0;
         if (src_valid && src_ready) begin
            hs_pend = 1;
            exp_q.push_back({BASE + AW'(src_idx), img[src_idx]});
         end
         if (ack) begin
            ack = 1'b0;
            ack_cnt = 0;
         end else if (!stb) begin
            ack_cnt = 0;
         end else if (acks_given < ack_stop_at) begin
            if (ack_cnt >= 1) begin
               ack = 1'b1;
               acks_given++;
               nwrites++;
               chk("cyc_we", 64'({cyc, we}), 64'd3);
               if (exp_q.size() > 0)
                  chk("write", {ADR_O, DAT_O}, exp_q.pop_front());
               else
                  chk("sb_extra", 64'(exp_q.size()), 64'd1);
            end else begin
               ack_cnt++;
            end
         end
         if (done) done_cnt++;
      end
      stb_prev = stb;
   end

   task automatic load(int n, logic [DW-1:0] d0);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(d0 + DW'(i));
      src_idx = 0;
      acks_given = 0;
      done_cnt = 0;
      nwrites = 0;
      phase = 0;
      len = AW'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 400) begin
         tick();
         n++;
      end
      chk("done_seen", 64'(done), 64'd1);
   endtask

   task automatic end_chk(int n);
      tick();
      chk("done_fall", 64'(done), 64'd0);
      chk("done_pulse", 64'(done_cnt), 64'd1);
      chk("core_sel", 64'(core_select), 64'd1);
      chk("cyc_off", 64'({cyc, stb, we, busy}), 64'd0);
      chk("words", 64'(words_written), 64'(n));
      chk("nwrites", 64'(nwrites), 64'(n));
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_stb(int ww);
      int k;
      k = 0;
      while (!(stb && words_written == AW'(ww)) && k < 200) begin
         tick();
         k++;
      end
      chk("stb_wait", 64'({stb, words_written}), {31'd0, 1'b1, AW'(ww)});
   endtask

   initial begin
      int n;
      int k;
      repeat (3) tick();
      chk("rst_ctl", 64'({cyc, stb, we, src_ready, core_select,
                          done, err, busy}), 64'd0);
      chk("rst_adr", 64'(ADR_O), 64'd0);
      chk("rst_dat", 64'(DAT_O), 64'd0);
      chk("rst_ww", 64'(words_written), 64'd0);
      reset = 1'b0;
      tick();

      // plain load, 3 cycles per word
      load(10, 32'hA000_0000);
      chk("start_cyc", 64'({cyc, stb, busy}), 64'd5);
      wait_done(n);
      chk("lat30", 64'(n), 64'd30);
      end_chk(10);

      // pause in FETCH after the 4th ack
      load(10, 32'hB000_0000);
      k = 0;
      while (words_written != 4 && k < 200) begin
         tick();
         k++;
      end
      chk("reach4", 64'(words_written), 64'd4);
      pause = 1'b1;
      repeat (11) tick();
      chk("p_bus", 64'({cyc, stb, src_ready}), 64'd4);
      chk("p_ww", 64'(words_written), 64'd4);
      pause = 1'b0;
      wait_done(n);
      end_chk(10);

      // pause while stb waits for ack
      load(3, 32'hC000_0000);
      wait_stb(1);
      pause = 1'b1;
      tick();
      chk("pw_bus", 64'({cyc, stb, busy}), 64'd5);
      chk("pw_adr", 64'(ADR_O), 64'(BASE + 1));
      chk("pw_dat", 64'(DAT_O), 64'h0000_0000_C000_0001);
      repeat (2) tick();
      chk("pw_hold", {ADR_O, DAT_O}, {BASE + 32'd1, 32'hC000_0001});
      pause = 1'b0;
      tick();
      chk("pw_stb", 64'(stb), 64'd1);
      chk("pw_re", {ADR_O, DAT_O}, {BASE + 32'd1, 32'hC000_0001});
      wait_done(n);
      end_chk(3);

      // sparse source: 1 cycle on, 3 off
      src_mode = 1;
      load(6, 32'hD000_0000);
      wait_done(n);
      end_chk(6);
      src_mode = 0;

      // ack timeout on 4th word
      ack_stop_at = 3;
      load(8, 32'hE000_0000);
      wait_stb(3);
      k = 0;
      while (!err && k < 100) begin
         tick();
         k++;
      end
      chk("tmo_cyc", 64'(k), 64'(TMO));
      chk("tmo_err", 64'(err), 64'd1);
      chk("tmo_bus", 64'({cyc, stb, we, core_select, busy, done}), 64'd0);
      chk("tmo_ww", 64'(words_written), 64'd3);
      chk("tmo_sb", 64'(exp_q.size()), 64'd1);
      exp_q.delete();
      ack_stop_at = 1 << 30;
      load(4, 32'hF000_0000);
      chk("err_clr", 64'(err), 64'd0);
      wait_done(n);
      end_chk(4);

      // zero-length load
      load(0, 32'h0);
      chk("z_done", 64'({done, core_select}), 64'd3);
      chk("z_bus", 64'({cyc, stb, busy}), 64'd0);
      tick();
      chk("z_fall", 64'({done, stb}), 64'd0);
      chk("z_pulse", 64'(done_cnt), 64'd1);
      chk("z_nw", 64'(nwrites), 64'd0);

      // reset in the middle of a write
      ack_stop_at = 0;
      load(3, 32'h1234_0000);
      wait_stb(0);
      reset = 1'b1;
      tick();
      chk("mr_ctl", 64'({cyc, stb, we, core_select, done, err, busy}),
          64'd0);
      chk("mr_adr", {ADR_O, DAT_O}, 64'd0);
      chk("mr_ww", 64'(words_written), 64'd0);
      reset = 1'b0;
      exp_q.delete();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
